// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, per-button debounce FSM, press/release pulses, sticky pending flag.
// Optional auto-repeat while held is built when LONG_PRESS_EN is defined.
module button_conditioner #(
    parameter int unsigned N               = 2,
    parameter int unsigned CNT_W           = 24,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned LONG_CYCLES     = 12000000,
    parameter int unsigned REPEAT_CYCLES   = 3000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] btn_async,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] press,
    output logic [N-1:0] release_pulse,
    output logic [N-1:0] repeat_pulse,
    output logic [N-1:0] pending,
    input  logic [N-1:0] pending_clr
);

    typedef enum logic [1:0] {IDLE, ARM_HI, HELD, ARM_LO} state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reject parameter sets the counters cannot represent.
    generate
        if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= REPEAT_CYCLES ||
            (64'(LONG_CYCLES) >> CNT_W) != 64'd0) begin : g_bad_cfg
            $error("button_conditioner: invalid parameter combination");
        end
    endgenerate

    logic [N-1:0] sync1;
    logic [N-1:0] sync2;
    logic [N-1:0] clr_q;

    // Two-stage synchroniser; firmware clear strobes are registered alongside.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            clr_q <= '0;
        end else begin
            sync1 <= btn_async;
            sync2 <= sync1;
            clr_q <= pending_clr;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_btn
        state_t           st;
        logic [CNT_W-1:0] cnt;
        logic             lvl;
        logic             prs;
        logic             rel;
        logic             rpt;
        logic             pnd;

        always_ff @(posedge clk) begin
            if (reset) begin
                st  <= IDLE;
                cnt <= '0;
                lvl <= 1'b0;
                prs <= 1'b0;
                rel <= 1'b0;
            end else begin
                prs <= 1'b0;
                rel <= 1'b0;
                case (st)
                    IDLE: begin
                        if (sync2[i]) begin
                            st  <= ARM_HI;
                            cnt <= CNT_W'(1);
                        end
                    end
                    ARM_HI: begin
                        if (!sync2[i]) begin
                            st  <= IDLE;
                            cnt <= '0;
                        end else if (cnt == DEB_LAST) begin
                            st  <= HELD;
                            cnt <= '0;
                            lvl <= 1'b1;
                            prs <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    HELD: begin
                        if (!sync2[i]) begin
                            st  <= ARM_LO;
                            cnt <= CNT_W'(1);
                        end
                    end
                    ARM_LO: begin
                        if (sync2[i]) begin
                            st  <= HELD;
                            cnt <= '0;
                        end else if (cnt == DEB_LAST) begin
                            st  <= IDLE;
                            cnt <= '0;
                            lvl <= 1'b0;
                            rel <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        st  <= IDLE;
                        cnt <= '0;
                    end
                endcase
            end
        end

`ifdef LONG_PRESS_EN
        localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
        localparam logic [CNT_W-1:0] RELOAD    = CNT_W'(LONG_CYCLES - REPEAT_CYCLES);
        logic [CNT_W-1:0] hold;

        // Hold timer runs only while staying in HELD; reload spaces later repeats by REPEAT_CYCLES.
        always_ff @(posedge clk) begin
            if (reset) begin
                hold <= '0;
                rpt  <= 1'b0;
            end else begin
                rpt <= 1'b0;
                if (st == HELD && sync2[i]) begin
                    if (hold == LONG_LAST) begin
                        hold <= RELOAD;
                        rpt  <= 1'b1;
                    end else begin
                        hold <= hold + CNT_W'(1);
                    end
                end else begin
                    hold <= '0;
                end
            end
        end
`else
        assign rpt = 1'b0;
`endif

        // Sticky flag: a set in the same cycle as a clear wins.
        always_ff @(posedge clk) begin
            if (reset) begin
                pnd <= 1'b0;
            end else begin
                pnd <= (pnd & ~clr_q[i]) | prs | rpt;
            end
        end

        assign btn_level[i]     = lvl;
        assign press[i]         = prs;
        assign release_pulse[i] = rel;
        assign repeat_pulse[i]  = rpt;
        assign pending[i]       = pnd;
    end

endmodule
